// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder fronting a bank of NREG full-word control registers.
// Write (AW/W/B) and read (AR/R) paths are independent; every register is also exported flat.
module axi_lite_slave_regs #(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned NREG = 8
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               AWVALID,
  input  logic [AW-1:0]      AWADDR,
  output logic               AWREADY,
  input  logic               WVALID,
  input  logic [DW-1:0]      WDATA,
  output logic               WREADY,
  output logic               BVALID,
  output logic [1:0]         BRESP,
  input  logic               BREADY,
  input  logic               ARVALID,
  input  logic [AW-1:0]      ARADDR,
  output logic               ARREADY,
  output logic               RVALID,
  output logic [DW-1:0]      RDATA,
  output logic [1:0]         RRESP,
  input  logic               RREADY,
  output logic [NREG*DW-1:0] REG_OUT
);

  localparam int unsigned XW = AW - 2;
  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t      w_state;
  r_state_t      r_state;
  logic          aw_held;
  logic          w_held;
  logic [XW-1:0] aw_idx_q;
  logic [DW-1:0] w_data_q;
  logic [DW-1:0] regs [NREG];

  // Byte-lane bits of the address carry no meaning for word-only registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, AWADDR[1:0], ARADDR[1:0]};

  assign AWREADY = (w_state == W_IDLE) && !aw_held;
  assign WREADY  = (w_state == W_IDLE) && !w_held;
  assign ARREADY = (r_state == R_IDLE);

  // Commit happens on the edge where both address and data are available.
  logic          aw_hs_c;
  logic          w_hs_c;
  logic          wr_fire_c;
  logic [XW-1:0] wr_idx_c;
  logic [DW-1:0] wr_data_c;
  logic          wr_ok_c;
  logic [XW-1:0] rd_idx_c;
  logic          rd_ok_c;

  assign aw_hs_c   = AWVALID && AWREADY;
  assign w_hs_c    = WVALID && WREADY;
  assign wr_fire_c = (w_state == W_IDLE) && (aw_held || aw_hs_c) && (w_held || w_hs_c);
  assign wr_idx_c  = aw_held ? aw_idx_q : AWADDR[AW-1:2];
  assign wr_data_c = w_held ? w_data_q : WDATA;
  assign wr_ok_c   = (wr_idx_c < XW'(NREG));
  assign rd_idx_c  = ARADDR[AW-1:2];
  assign rd_ok_c   = (rd_idx_c < XW'(NREG));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wr_fire_c && wr_ok_c) begin
      regs[IW'(wr_idx_c)] <= wr_data_c;
    end
  end

  for (genvar g = 0; g < int'(NREG); g++) begin : g_reg_out
    assign REG_OUT[g*DW +: DW] = regs[g];
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs_c) begin
            aw_held  <= 1'b1;
            aw_idx_q <= AWADDR[AW-1:2];
          end
          if (w_hs_c) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
          end
          if (wr_fire_c) begin
            BVALID  <= 1'b1;
            BRESP   <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read capture uses the pre-edge register value, so a same-edge write is not visible.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= R_IDLE;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            RVALID  <= 1'b1;
            RDATA   <= rd_ok_c ? regs[IW'(rd_idx_c)] : '0;
            RRESP   <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: responses are predicted at issue and compared at handshake.
module tb_axi_lite_slave_regs;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned NREG = 8;
  localparam int unsigned FW   = NREG * DW;

  logic          CLK = 1'b0;
  logic          RESETn;
  logic          AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA;
  logic          AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]    BRESP, RRESP;
  logic [DW-1:0] RDATA;
  logic [FW-1:0] REG_OUT;

  axi_lite_slave_regs #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .REG_OUT(REG_OUT)
  );

  always #5 CLK = ~CLK;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [DW-1:0] model [NREG];
  logic [1:0]    b_q [$];
  logic [33:0]   r_q [$];

  task automatic check_eq(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] flat();
    logic [FW-1:0] f;
    for (int i = 0; i < int'(NREG); i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> 2) < AW'(NREG);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Predict the write outcome and update the model at issue time.
  task automatic push_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (in_range(addr)) begin
      b_q.push_back(2'b00);
      model[3'(addr >> 2)] = data;
    end else begin
      b_q.push_back(2'b10);
    end
  endtask

  task automatic push_read(input logic [AW-1:0] addr);
    if (in_range(addr)) r_q.push_back({2'b00, model[3'(addr >> 2)]});
    else                r_q.push_back({2'b10, 32'h0});
  endtask

  task automatic wait_b();
    logic done = 1'b0;
    BREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!BVALID) begin done = 1'b1; break; end
    end
    BREADY = 1'b0;
    if (!done) check_eq("b_timeout", 0, 1);
  endtask

  task automatic wait_r();
    logic done = 1'b0;
    RREADY = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!RVALID) begin done = 1'b1; break; end
    end
    RREADY = 1'b0;
    if (!done) check_eq("r_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int bdelay);
    AWVALID = 1'b1; AWADDR = addr; WVALID = 1'b1; WDATA = data;
    check_eq("awready_idle", AWREADY, 1);
    check_eq("wready_idle", WREADY, 1);
    push_write(addr, data);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("bvalid_latency", BVALID, 1);
    for (int i = 0; i < bdelay; i++) begin
      tick();
      check_eq("bvalid_hold", BVALID, 1);
    end
    wait_b();
    check_eq("reg_out", REG_OUT, flat());
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int rdelay);
    ARVALID = 1'b1; ARADDR = addr;
    check_eq("arready_idle", ARREADY, 1);
    push_read(addr);
    tick();
    ARVALID = 1'b0;
    check_eq("rvalid_latency", RVALID, 1);
    check_eq("arready_busy", ARREADY, 0);
    for (int i = 0; i < rdelay; i++) begin
      tick();
      check_eq("rvalid_hold", RVALID, 1);
    end
    wait_r();
  endtask

  // Scoreboard: compare on the cycle a response handshake is about to complete.
  always @(negedge CLK) begin
    if (RESETn) begin
      if (BVALID && BREADY) begin
        if (b_q.size() == 0) check_eq("b_unexpected", 1, 0);
        else check_eq("bresp", BRESP, b_q.pop_front());
      end
      if (RVALID && RREADY) begin
        if (r_q.size() == 0) begin
          check_eq("r_unexpected", 1, 0);
        end else begin
          logic [33:0] e;
          e = r_q.pop_front();
          check_eq("rdata", RDATA, e[31:0]);
          check_eq("rresp", RRESP, e[33:32]);
        end
      end
    end
  end

  initial begin
    RESETn = 1'b0;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; ARADDR = '0; WDATA = '0;
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;

    // Reset state
    repeat (3) tick();
    check_eq("rst_reg_out", REG_OUT, '0);
    check_eq("rst_bvalid", BVALID, 0);
    check_eq("rst_rvalid", RVALID, 0);
    check_eq("rst_awready", AWREADY, 1);
    check_eq("rst_wready", WREADY, 1);
    check_eq("rst_arready", ARREADY, 1);
    RESETn = 1'b1;
    tick();
    check_eq("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    do_read(32'h4, 0);

    // Aligned write, AW and W together
    do_write(32'h08, 32'hDEADBEEF, 0);
    check_eq("reg2_slice", REG_OUT[95:64], 32'hDEADBEEF);
    do_read(32'h08, 1);

    // W three cycles ahead of AW, slow BREADY
    WVALID = 1'b1; WDATA = 32'hCAFEF00D;
    tick();
    WVALID = 1'b0;
    check_eq("wready_held", WREADY, 0);
    check_eq("awready_wait", AWREADY, 1);
    check_eq("bvalid_early", BVALID, 0);
    tick(); tick();
    check_eq("bvalid_no_aw", BVALID, 0);
    AWVALID = 1'b1; AWADDR = 32'h10;
    push_write(32'h10, 32'hCAFEF00D);
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("split_bvalid", BVALID, 1);
      check_eq("split_bresp", BRESP, 2'b00);
      check_eq("split_awready", AWREADY, 0);
      check_eq("split_wready", WREADY, 0);
      tick();
    end
    wait_b();
    check_eq("split_reg_out", REG_OUT, flat());

    // Out-of-range and upper-boundary addresses
    do_write(32'h20, 32'hFFFFFFFF, 1);
    do_read(32'h20, 0);
    do_write(32'h1F, 32'h00000077, 0);
    do_read(32'h1C, 0);

    // Same-edge read and write of one register
    ARVALID = 1'b1; ARADDR = 32'h0C;
    AWVALID = 1'b1; AWADDR = 32'h0C; WVALID = 1'b1; WDATA = 32'h12345678;
    push_read(32'h0C);
    push_write(32'h0C, 32'h12345678);
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("same_bvalid", BVALID, 1);
    BREADY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_eq("same_rvalid_hold", RVALID, 1);
      check_eq("same_rdata_old", RDATA, 32'h0);
      check_eq("same_arready", ARREADY, 0);
      tick();
    end
    BREADY = 1'b0;
    check_eq("same_b_done", BVALID, 0);
    wait_r();
    do_read(32'h0C, 0);

    // Random traffic against the model
    for (int n = 0; n < 8; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 9)) << 2;
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom, int'($urandom_range(0, 2)));
      else do_read(a, int'($urandom_range(0, 2)));
    end

    // Reset while a write response is pending
    AWVALID = 1'b1; AWADDR = 32'h0; WVALID = 1'b1; WDATA = 32'h55;
    push_write(32'h0, 32'h55);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("pre_rst_bvalid", BVALID, 1);
    #2;
    RESETn = 1'b0;
    b_q.delete();
    r_q.delete();
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
    #1;
    check_eq("mid_rst_bvalid", BVALID, 0);
    check_eq("mid_rst_reg_out", REG_OUT, '0);
    check_eq("mid_rst_ready", {AWREADY, WREADY}, 2'b11);
    tick();
    RESETn = 1'b1;
    tick();
    do_write(32'h04, 32'hA5A5A5A5, 0);
    do_read(32'h04, 0);

    check_eq("b_q_drained", 32'(b_q.size()), 0);
    check_eq("r_q_drained", 32'(r_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
